// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage driving a single-outstanding req/ack data bus
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  excp_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  wdl_q, wdl_d;
    logic        wrl_q, wrl_d;
    logic        valid_q, valid_d, wreg_q, wreg_d, req_q, req_d, we_q, we_d;
    logic [4:0]  wd_q, wd_d;
    logic [31:0] wdata_q, wdata_d, addr_q, addr_d, bwdata_q, bwdata_d;
    logic [1:0]  excp_q, excp_d;
    logic [3:0]  sel_q, sel_d;

    logic        is_ld, is_st, is_b, is_h, is_w, misal, start, ld_q, tmo;
    logic [31:0] rsh, ld_val;
    logic [7:0]  rb;
    logic [15:0] rh;

    assign is_ld = mem_op_i >= 4'd1 && mem_op_i <= 4'd5;
    assign is_st = mem_op_i >= 4'd6 && mem_op_i <= 4'd8;
    assign is_b  = mem_op_i == 4'd1 || mem_op_i == 4'd2 || mem_op_i == 4'd6;
    assign is_h  = mem_op_i == 4'd3 || mem_op_i == 4'd4 || mem_op_i == 4'd7;
    assign is_w  = mem_op_i == 4'd5 || mem_op_i == 4'd8;
    assign misal = (is_h && mem_addr_i[0]) || (is_w && mem_addr_i[1:0] != 2'b00);
    assign start = valid_i && (is_ld || is_st) && !misal;
    assign tmo   = cnt_q == 8'(TIMEOUT - 1);
    assign ld_q  = op_q <= 4'd5;

    // big-endian lane pick: byte offset 0 lives in [31:24]
    assign rsh    = bus_rdata >> {~lo_q, 3'b000};
    assign rb     = rsh[7:0];
    assign rh     = lo_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    assign ld_val = op_q == 4'd1 ? {{24{rb[7]}}, rb} :
                    op_q == 4'd2 ? {24'd0, rb} :
                    op_q == 4'd3 ? {{16{rh[15]}}, rh} :
                    op_q == 4'd4 ? {16'd0, rh} : bus_rdata;

    assign stall_o = !rst && (state_q == IDLE ? start : !bus_ack);

    assign valid_o   = valid_q;
    assign wd_o      = wd_q;
    assign wreg_o    = wreg_q;
    assign wdata_o   = wdata_q;
    assign excp_o    = excp_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_sel   = sel_q;
    assign bus_wdata = bwdata_q;

    // next-state: issue, complete or time out bus accesses; pass everything else through
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        lo_d     = lo_q;
        wdl_d    = wdl_q;
        wrl_d    = wrl_q;
        valid_d  = valid_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        excp_d   = excp_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        bwdata_d = bwdata_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d  = ACCESS;
                cnt_d    = 8'd0;
                op_d     = mem_op_i;
                lo_d     = mem_addr_i[1:0];
                wdl_d    = wd_i;
                wrl_d    = wreg_i;
                valid_d  = 1'b0;
                wreg_d   = 1'b0;
                excp_d   = 2'd0;
                req_d    = 1'b1;
                we_d     = is_st;
                addr_d   = {mem_addr_i[31:2], 2'b00};
                sel_d    = is_b ? 4'b1000 >> mem_addr_i[1:0] :
                           is_h ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
                bwdata_d = is_b ? {4{mem_data_i[7:0]}} :
                           is_h ? {2{mem_data_i[15:0]}} : mem_data_i;
            end else begin
                valid_d = valid_i;
                wd_d    = wd_i;
                wdata_d = wdata_i;
                wreg_d  = wreg_i && valid_i && !misal;
                excp_d  = (valid_i && misal) ? 2'd1 : 2'd0;
            end
        end else if (bus_ack || tmo) begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b1;
            wd_d    = wdl_q;
            wreg_d  = bus_ack && ld_q && wrl_q;
            wdata_d = (bus_ack && ld_q) ? ld_val : 32'd0;
            excp_d  = bus_ack ? 2'd0 : 2'd2;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            wdl_q    <= '0;
            wrl_q    <= 1'b0;
            valid_q  <= 1'b0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            excp_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            lo_q     <= lo_d;
            wdl_q    <= wdl_d;
            wrl_q    <= wrl_d;
            valid_q  <= valid_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            excp_q   <= excp_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            bwdata_q <= bwdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access with TIMEOUT = 4
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        stall_o, valid_o, wreg_o, bus_req, bus_we;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o, bus_addr, bus_wdata;
    logic [1:0]  excp_o;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .excp_o(excp_o), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] alu);
        valid_i = 1'b1;
        mem_op_i = op;
        mem_addr_i = addr;
        mem_data_i = data;
        wd_i = wd;
        wreg_i = wreg;
        wdata_i = alu;
    endtask

    // full load/store: issue, n_wait ACCESS cycles without ack, then ack
    task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int n_wait,
                          input logic [3:0] e_sel, input logic e_we, input logic [31:0] e_bw,
                          input logic [31:0] e_res, input logic e_wreg);
        drive(op, addr, data, 5'd9, 1'b1, 32'hDEAD_0000);
        #1 check({tag, " stall@issue"}, 32'(stall_o), 32'd1);
        step();
        check({tag, " req"}, 32'(bus_req), 32'd1);
        check({tag, " addr"}, bus_addr, {addr[31:2], 2'b00});
        check({tag, " sel"}, 32'(bus_sel), 32'(e_sel));
        check({tag, " we"}, 32'(bus_we), 32'(e_we));
        if (e_we) check({tag, " wdata"}, bus_wdata, e_bw);
        check({tag, " valid busy"}, 32'(valid_o), 32'd0);
        for (int i = 0; i < n_wait; i++) begin
            #1 check({tag, " stall wait"}, 32'(stall_o), 32'd1);
            step();
            check({tag, " req held"}, 32'(bus_req), 32'd1);
            check({tag, " sel held"}, 32'(bus_sel), 32'(e_sel));
            if (e_we) check({tag, " wdata held"}, bus_wdata, e_bw);
        end
        bus_rdata = rdata;
        bus_ack = 1'b1;
        #1 check({tag, " stall@ack"}, 32'(stall_o), 32'd0);
        step();
        valid_i = 1'b0;
        bus_ack = 1'b0;
        check({tag, " valid_o"}, 32'(valid_o), 32'd1);
        check({tag, " wd_o"}, 32'(wd_o), 32'd9);
        check({tag, " wreg_o"}, 32'(wreg_o), 32'(e_wreg));
        check({tag, " wdata_o"}, wdata_o, e_res);
        check({tag, " excp_o"}, 32'(excp_o), 32'd0);
        check({tag, " req done"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        #2;
        check("rst stall", 32'(stall_o), 32'd0);
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst req", 32'(bus_req), 32'd0);
        check("rst wdata", wdata_o, 32'd0);
        step();
        rst = 1'b0;
        step();

        drive(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678);
        #1 check("pass stall", 32'(stall_o), 32'd0);
        step();
        valid_i = 1'b0;
        check("pass valid", 32'(valid_o), 32'd1);
        check("pass wd", 32'(wd_o), 32'd3);
        check("pass wreg", 32'(wreg_o), 32'd1);
        check("pass wdata", wdata_o, 32'h1234_5678);
        check("pass excp", 32'(excp_o), 32'd0);

        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("idle ack req", 32'(bus_req), 32'd0);
        check("idle ack valid", 32'(valid_o), 32'd0);

        mem_op("LB", 4'd1, 32'h101, 32'h0, 32'h0080_0000, 0, 4'b0100, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b1);
        mem_op("SH", 4'd7, 32'h202, 32'h0000_BEEF, 32'h0, 3, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0);
        mem_op("SB", 4'd6, 32'h303, 32'h1234_56A5, 32'h0, 1, 4'b0001, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
        mem_op("LHU", 4'd4, 32'h102, 32'h0, 32'h1234_8001, 0, 4'b0011, 1'b0, 32'h0, 32'h0000_8001, 1'b1);
        mem_op("LH", 4'd3, 32'h100, 32'h0, 32'h8001_0000, 2, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001, 1'b1);
        mem_op("LBU", 4'd2, 32'h100, 32'h0, 32'h9A00_0000, 0, 4'b1000, 1'b0, 32'h0, 32'h0000_009A, 1'b1);
        mem_op("SW", 4'd8, 32'h400, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0);

        drive(4'd5, 32'h6, 32'h0, 5'd4, 1'b1, 32'h55);
        #1 check("mis stall", 32'(stall_o), 32'd0);
        step();
        valid_i = 1'b0;
        check("mis req", 32'(bus_req), 32'd0);
        check("mis valid", 32'(valid_o), 32'd1);
        check("mis wreg", 32'(wreg_o), 32'd0);
        check("mis excp", 32'(excp_o), 32'd1);

        drive(4'd5, 32'h40, 32'h0, 5'd6, 1'b1, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            #1 check("tmo stall", 32'(stall_o), 32'd1);
            step();
            check("tmo req held", 32'(bus_req), 32'd1);
            check("tmo valid busy", 32'(valid_o), 32'd0);
        end
        step();
        valid_i = 1'b0;
        check("tmo req", 32'(bus_req), 32'd0);
        check("tmo valid", 32'(valid_o), 32'd1);
        check("tmo wreg", 32'(wreg_o), 32'd0);
        check("tmo excp", 32'(excp_o), 32'd2);
        #1 check("tmo idle stall", 32'(stall_o), 32'd0);

        mem_op("LW ack4", 4'd5, 32'h44, 32'h0, 32'h0BAD_BEEF, 3, 4'b1111, 1'b0, 32'h0, 32'h0BAD_BEEF, 1'b1);

        drive(4'd5, 32'h80, 32'h0, 5'd2, 1'b1, 32'h0);
        step();
        check("rst mid req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst async req", 32'(bus_req), 32'd0);
        check("rst async stall", 32'(stall_o), 32'd0);
        check("rst async sel", 32'(bus_sel), 32'd0);
        valid_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post rst valid", 32'(valid_o), 32'd0);
        mem_op("LW post", 4'd5, 32'h10, 32'h0, 32'h7654_3210, 0, 4'b1111, 1'b0, 32'h0, 32'h7654_3210, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
